// File: rtl/usb_decoder_if.sv
// Receive-side bundle for the USB decoder: strobe and line inputs, byte/status outputs.
// dbg_state mirrors the decoder FSM so checkers can bind to it.
interface usb_decoder_if;
    logic       clk12;
    logic       dplus_in;
    logic       dminus_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       eop_detected;
    logic       rx_error;
    logic [1:0] dbg_state;

    // Handshake: no ready. The decoder samples the line only on clk edges with clk12=1;
    // rx_valid, eop_detected and rx_error are single-clk pulses the consumer must take as they come.
    modport master (
        output clk12, dplus_in, dminus_in,
        input  rx_data, rx_valid, rx_active, eop_detected, rx_error, dbg_state
    );

    modport slave (
        input  clk12, dplus_in, dminus_in,
        output rx_data, rx_valid, rx_active, eop_detected, rx_error, dbg_state
    );
endinterface

// File: rtl/usb_decoder.sv
// USB full-speed receive path: NRZI decode, SYNC hunt, bit unstuffing, byte assembly
// and EOP checking. All outputs are registered.
module usb_decoder (
    input logic          clk,
    input logic          rst,
    usb_decoder_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_EOP   = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [1:0] state, state_d;
    logic       prev_dp, prev_dp_d;
    logic [7:0] sync_sr, sync_sr_d;
    logic [7:0] data_sr, data_sr_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [2:0] ones_cnt, ones_cnt_d;
    logic [1:0] se0_cnt, se0_cnt_d;
    logic [2:0] j_cnt, j_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       eop_q, eop_d;
    logic       err_q, err_d;
    logic       active_q, active_d;

    logic       se0, line_j, dbit;
    logic [7:0] sync_shift, data_shift;

    // (1,1) is illegal on the bus and is folded into SE0.
    assign se0        = (bus.dplus_in == bus.dminus_in);
    assign line_j     = bus.dplus_in & ~bus.dminus_in;
    assign dbit       = (bus.dplus_in == prev_dp);
    assign sync_shift = {dbit, sync_sr[7:1]};
    assign data_shift = {dbit, data_sr[7:1]};

    always_comb begin
        state_d    = state;
        prev_dp_d  = prev_dp;
        sync_sr_d  = sync_sr;
        data_sr_d  = data_sr;
        bit_cnt_d  = bit_cnt;
        ones_cnt_d = ones_cnt;
        se0_cnt_d  = se0_cnt;
        j_cnt_d    = j_cnt;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;

        if (bus.clk12) begin
            if (!se0) prev_dp_d = bus.dplus_in;
            case (state)
                S_IDLE: begin
                    if (!se0) begin
                        sync_sr_d = sync_shift;
                        if (sync_shift == 8'h80) begin
                            state_d    = S_RECV;
                            bit_cnt_d  = 3'd0;
                            ones_cnt_d = 3'd1;
                        end
                    end
                end
                S_RECV: begin
                    if (se0) begin
                        state_d   = S_EOP;
                        se0_cnt_d = 2'd1;
                        bit_cnt_d = 3'd0;
                        if (bit_cnt != 3'd0) err_d = 1'b1;
                    end else if (ones_cnt == 3'd6) begin
                        // Six ones in a row: this sample must be a stuffed zero.
                        if (dbit) begin
                            err_d   = 1'b1;
                            state_d = S_ERROR;
                            j_cnt_d = 3'd0;
                        end else begin
                            ones_cnt_d = 3'd0;
                        end
                    end else begin
                        data_sr_d  = data_shift;
                        bit_cnt_d  = bit_cnt + 3'd1;
                        ones_cnt_d = dbit ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            rx_data_d  = data_shift;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                S_EOP: begin
                    if (se0) begin
                        if (se0_cnt != 2'd3) se0_cnt_d = se0_cnt + 2'd1;
                    end else if (line_j) begin
                        state_d = S_IDLE;
                        if (se0_cnt >= 2'd2) begin
                            eop_d     = 1'b1;
                            prev_dp_d = 1'b1;
                            sync_sr_d = 8'hFF;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                        j_cnt_d = 3'd0;
                    end
                end
                default: begin
                    if (line_j) begin
                        if (j_cnt == 3'd7) begin
                            state_d   = S_IDLE;
                            prev_dp_d = 1'b1;
                            sync_sr_d = 8'hFF;
                            j_cnt_d   = 3'd0;
                        end else begin
                            j_cnt_d = j_cnt + 3'd1;
                        end
                    end else begin
                        j_cnt_d = 3'd0;
                    end
                end
            endcase
        end
        active_d = (state_d == S_RECV) || (state_d == S_EOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_dp    <= 1'b1;
            sync_sr    <= 8'hFF;
            data_sr    <= 8'h00;
            bit_cnt    <= 3'd0;
            ones_cnt   <= 3'd0;
            se0_cnt    <= 2'd0;
            j_cnt      <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state      <= state_d;
            prev_dp    <= prev_dp_d;
            sync_sr    <= sync_sr_d;
            data_sr    <= data_sr_d;
            bit_cnt    <= bit_cnt_d;
            ones_cnt   <= ones_cnt_d;
            se0_cnt    <= se0_cnt_d;
            j_cnt      <= j_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
            active_q   <= active_d;
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_active    = active_q;
    assign bus.eop_detected = eop_q;
    assign bus.rx_error     = err_q;
    assign bus.dbg_state    = state;
endmodule
